// File: rtl/reg_wr_arbiter.sv
// -----------------------------------------------------------------------------
// reg_wr_arbiter
//
// Shares the single register-file write port between two writeback
// requesters (wb0 = ALU, wb1 = load/memory). Requests use valid/ready
// handshakes and are arbitrated round-robin. The winning write is registered
// for one cycle in front of the register file. While that registered write
// is pending, the register-file read data is bypassed so that decode sees the
// new value. Writes to register 0 are accepted but discarded. Committed and
// dropped writes are counted.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : synchronous, active-high reset
//   stall          : 1 = grant nothing this cycle
//   wb0_valid/index/data, wb0_ready : requester 0 handshake and payload
//   wb1_valid/index/data, wb1_ready : requester 1 handshake and payload
//   rf_wr_en/index/data             : registered write to reg_file
//   rd_reg_index_1/2                : decode read indices (also drive reg_file)
//   reg_data_1/2                    : raw reg_file read data
//   rd_data_1/2                     : bypassed read data (combinational)
//   hazard_1/2                      : read port hits the pending write
//   wr_count                        : committed writes, wraps
//   drop_count                      : accepted writes to register 0, wraps
// -----------------------------------------------------------------------------
module reg_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,

    input  logic              wb0_valid,
    input  logic [IDX_W-1:0]  wb0_index,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,

    input  logic              wb1_valid,
    input  logic [IDX_W-1:0]  wb1_index,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,

    output logic              rf_wr_en,
    output logic [IDX_W-1:0]  rf_wr_index,
    output logic [DATA_W-1:0] rf_wr_data,

    input  logic [IDX_W-1:0]  rd_reg_index_1,
    input  logic [IDX_W-1:0]  rd_reg_index_2,
    input  logic [DATA_W-1:0] reg_data_1,
    input  logic [DATA_W-1:0] reg_data_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              hazard_1,
    output logic              hazard_2,

    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  drop_count
);

    // -------------------------------------------------------------------------
    // Requester and read-port views as small arrays so the per-lane logic can
    // be generated uniformly.
    // -------------------------------------------------------------------------
    logic [1:0]        req_valid;
    logic [IDX_W-1:0]  req_index [2];
    logic [DATA_W-1:0] req_data  [2];
    logic [1:0]        grant;

    assign req_valid    = {wb1_valid, wb0_valid};
    assign req_index[0] = wb0_index;
    assign req_index[1] = wb1_index;
    assign req_data[0]  = wb0_data;
    assign req_data[1]  = wb1_data;

    logic [IDX_W-1:0]  rd_idx   [2];
    logic [DATA_W-1:0] rd_raw   [2];
    logic [DATA_W-1:0] rd_byp   [2];
    logic [1:0]        rd_hit;

    assign rd_idx[0] = rd_reg_index_1;
    assign rd_idx[1] = rd_reg_index_2;
    assign rd_raw[0] = reg_data_1;
    assign rd_raw[1] = reg_data_2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic              rr_ptr_q,      rr_ptr_d;
    logic              wr_en_q,       wr_en_d;
    logic [IDX_W-1:0]  wr_index_q,    wr_index_d;
    logic [DATA_W-1:0] wr_data_q,     wr_data_d;
    logic [CNT_W-1:0]  wr_count_q,    wr_count_d;
    logic [CNT_W-1:0]  drop_count_q,  drop_count_d;

    // -------------------------------------------------------------------------
    // Grant: a requester wins when it is valid and either the other side is
    // idle or the round-robin pointer favours it. The two conditions are
    // mutually exclusive, so at most one grant is ever high, and a grant
    // never appears without its valid.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = ~rst & ~stall & req_valid[gi]
                             & (~req_valid[1-gi] | (rr_ptr_q == 1'(gi)));
        end
    endgenerate

    assign wb0_ready = grant[0];
    assign wb1_ready = grant[1];

    // Winner payload; grant[1] alone picks the lane since grants are one-hot.
    logic              xfer;
    logic              win;
    logic [IDX_W-1:0]  win_index;
    logic [DATA_W-1:0] win_data;

    assign xfer      = |grant;
    assign win       = grant[1];
    assign win_index = win ? req_index[1] : req_index[0];
    assign win_data  = win ? req_data[1]  : req_data[0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        wr_en_d      = 1'b0;
        wr_index_d   = wr_index_q;
        wr_data_d    = wr_data_q;
        wr_count_d   = wr_count_q;
        drop_count_d = drop_count_q;

        if (xfer) begin
            // Pointer moves away from whoever just won, even when it was
            // the only requester.
            rr_ptr_d = ~win;
            if (win_index != '0) begin
                wr_en_d    = 1'b1;
                wr_index_d = win_index;
                wr_data_d  = win_data;
                wr_count_d = wr_count_q + CNT_W'(1);
            end else begin
                drop_count_d = drop_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_index_q   <= '0;
            wr_data_q    <= '0;
            wr_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wr_en_q      <= wr_en_d;
            wr_index_q   <= wr_index_d;
            wr_data_q    <= wr_data_d;
            wr_count_q   <= wr_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Write port. The register file commits at the edge that ends the cycle
    // in which rf_wr_en is high, so a reset raised during that cycle must also
    // mask the enable; otherwise the pending write would slip into reg_file
    // at the same edge that clears this stage.
    // -------------------------------------------------------------------------
    logic wr_live;

    assign wr_live     = wr_en_q & ~rst;
    assign rf_wr_en    = wr_live;
    assign rf_wr_index = wr_index_q;
    assign rf_wr_data  = wr_data_q;

    // -------------------------------------------------------------------------
    // Read bypass. Register 0 can never match because the enable is never
    // set for an index-0 write.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
            assign rd_hit[gi] = wr_live & (wr_index_q == rd_idx[gi]);
            assign rd_byp[gi] = rd_hit[gi] ? wr_data_q : rd_raw[gi];
        end
    endgenerate

    assign hazard_1  = rd_hit[0];
    assign hazard_2  = rd_hit[1];
    assign rd_data_1 = rd_byp[0];
    assign rd_data_2 = rd_byp[1];

    assign wr_count   = wr_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_wr_arbiter
//
// Directed bench for reg_wr_arbiter: reset, single write, round-robin
// contention, register-0 drop, read bypass, stall and reset mid-operation.
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further unit later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_reg_wr_arbiter;

    localparam int DW = 32;
    localparam int IW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          wb0_valid, wb1_valid;
    logic [IW-1:0] wb0_index, wb1_index;
    logic [DW-1:0] wb0_data,  wb1_data;
    logic          wb0_ready, wb1_ready;
    logic          rf_wr_en;
    logic [IW-1:0] rf_wr_index;
    logic [DW-1:0] rf_wr_data;
    logic [IW-1:0] rd_reg_index_1, rd_reg_index_2;
    logic [DW-1:0] reg_data_1, reg_data_2;
    logic [DW-1:0] rd_data_1, rd_data_2;
    logic          hazard_1, hazard_2;
    logic [CW-1:0] wr_count, drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_wr_arbiter #(
        .DATA_W (DW),
        .IDX_W  (IW),
        .CNT_W  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .wb0_valid      (wb0_valid),
        .wb0_index      (wb0_index),
        .wb0_data       (wb0_data),
        .wb0_ready      (wb0_ready),
        .wb1_valid      (wb1_valid),
        .wb1_index      (wb1_index),
        .wb1_data       (wb1_data),
        .wb1_ready      (wb1_ready),
        .rf_wr_en       (rf_wr_en),
        .rf_wr_index    (rf_wr_index),
        .rf_wr_data     (rf_wr_data),
        .rd_reg_index_1 (rd_reg_index_1),
        .rd_reg_index_2 (rd_reg_index_2),
        .reg_data_1     (reg_data_1),
        .reg_data_2     (reg_data_2),
        .rd_data_1      (rd_data_1),
        .rd_data_2      (rd_data_2),
        .hazard_1       (hazard_1),
        .hazard_2       (hazard_2),
        .wr_count       (wr_count),
        .drop_count     (drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    // Contention table: cycle i presents wb0 idx 1+i / data 100+i and
    // wb1 idx 11+i / data 200+i, starting from rr_ptr = 0.
    logic          con_r0  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [IW-1:0] con_idx [4] = '{5'd1, 5'd12, 5'd3, 5'd14};
    logic [DW-1:0] con_dat [4] = '{32'd100, 32'd201, 32'd102, 32'd203};

    initial begin
        rst = 1'b1; stall = 1'b0;
        wb0_valid = 1'b1; wb0_index = 5'd3; wb0_data = 32'h11;
        wb1_valid = 1'b1; wb1_index = 5'd4; wb1_data = 32'h22;
        rd_reg_index_1 = '0; rd_reg_index_2 = '0;
        reg_data_1 = '0; reg_data_2 = '0;

        // 1. Reset
        settle();
        chk("rst_ready0", 64'(wb0_ready), 64'd0);
        chk("rst_ready1", 64'(wb1_ready), 64'd0);
        cyc();
        chk("rst_wr_en",   64'(rf_wr_en),    64'd0);
        chk("rst_wr_idx",  64'(rf_wr_index), 64'd0);
        chk("rst_wr_data", 64'(rf_wr_data),  64'd0);
        chk("rst_wr_cnt",  64'(wr_count),    64'd0);
        chk("rst_drop",    64'(drop_count),  64'd0);
        rst = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
        $display("reset done");

        // 2. Single write wb0 idx 5 data 1234
        wb0_valid = 1'b1; wb0_index = 5'd5; wb0_data = 32'd1234;
        settle();
        chk("single_ready0", 64'(wb0_ready), 64'd1);
        chk("single_ready1", 64'(wb1_ready), 64'd0);
        cyc();
        wb0_valid = 1'b0;
        settle();
        chk("single_wr_en",  64'(rf_wr_en),    64'd1);
        chk("single_idx",    64'(rf_wr_index), 64'd5);
        chk("single_data",   64'(rf_wr_data),  64'd1234);
        cyc();
        chk("single_en_off", 64'(rf_wr_en),    64'd0);
        chk("single_cnt",    64'(wr_count),    64'd1);
        chk("single_hold",   64'(rf_wr_index), 64'd5);
        $display("single write idx 5 data 1234");

        // wb1 alone (idx 9) moves rr_ptr back to 0
        wb1_valid = 1'b1; wb1_index = 5'd9; wb1_data = 32'h55;
        settle();
        chk("solo1_ready1", 64'(wb1_ready), 64'd1);
        chk("solo1_ready0", 64'(wb0_ready), 64'd0);
        cyc();
        wb1_valid = 1'b0;
        settle();
        chk("solo1_idx", 64'(rf_wr_index), 64'd9);
        $display("single write wb1 idx 9");

        // 3. Contention
        wb0_valid = 1'b1; wb1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb0_index = IW'(1 + i);  wb0_data = DW'(100 + i);
            wb1_index = IW'(11 + i); wb1_data = DW'(200 + i);
            settle();
            chk("con_ready0", 64'(wb0_ready), 64'(con_r0[i]));
            chk("con_ready1", 64'(wb1_ready), 64'(!con_r0[i]));
            if (i > 0) begin
                chk("con_wr_en", 64'(rf_wr_en),    64'd1);
                chk("con_idx",   64'(rf_wr_index), 64'(con_idx[i-1]));
                chk("con_data",  64'(rf_wr_data),  64'(con_dat[i-1]));
            end
            $display("contention cycle %0d grant wb%0d", i, con_r0[i] ? 0 : 1);
            cyc();
        end
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        settle();
        chk("con_wr_en_last", 64'(rf_wr_en),    64'd1);
        chk("con_idx_last",   64'(rf_wr_index), 64'(con_idx[3]));
        chk("con_data_last",  64'(rf_wr_data),  64'(con_dat[3]));
        cyc();
        chk("con_en_off", 64'(rf_wr_en), 64'd0);
        chk("con_cnt",    64'(wr_count), 64'd6);

        // 4. Register 0 write from wb1
        wb1_valid = 1'b1; wb1_index = 5'd0; wb1_data = 32'd2431;
        settle();
        chk("r0_ready1", 64'(wb1_ready), 64'd1);
        cyc();
        wb1_valid = 1'b0;
        rd_reg_index_1 = 5'd0; reg_data_1 = '0;
        settle();
        chk("r0_wr_en", 64'(rf_wr_en),    64'd0);
        chk("r0_drop",  64'(drop_count),  64'd1);
        chk("r0_cnt",   64'(wr_count),    64'd6);
        chk("r0_hold",  64'(rf_wr_index), 64'd14);
        chk("r0_haz1",  64'(hazard_1),    64'd0);
        chk("r0_rd1",   64'(rd_data_1),   64'd0);
        $display("register 0 write dropped");

        // 5. Bypass
        wb0_valid = 1'b1; wb0_index = 5'd7; wb0_data = 32'd99;
        settle();
        chk("byp_ready0", 64'(wb0_ready), 64'd1);
        cyc();
        wb0_valid = 1'b0;
        rd_reg_index_1 = 5'd7; reg_data_1 = 32'd0;
        rd_reg_index_2 = 5'd8; reg_data_2 = 32'hABCD;
        settle();
        chk("byp_haz1", 64'(hazard_1),  64'd1);
        chk("byp_rd1",  64'(rd_data_1), 64'd99);
        chk("byp_haz2", 64'(hazard_2),  64'd0);
        chk("byp_rd2",  64'(rd_data_2), 64'hABCD);
        cyc();
        reg_data_1 = 32'd5;
        settle();
        chk("byp_haz1_off", 64'(hazard_1),  64'd0);
        chk("byp_rd1_off",  64'(rd_data_1), 64'd5);
        chk("byp_cnt",      64'(wr_count),  64'd7);
        $display("bypass idx 7 data 99");

        // 6a. Stall with both valid; rr_ptr is 1 and must stay 1
        stall = 1'b1;
        wb0_valid = 1'b1; wb0_index = 5'd16; wb0_data = 32'h600;
        wb1_valid = 1'b1; wb1_index = 5'd20; wb1_data = 32'h777;
        settle();
        chk("stall_ready0", 64'(wb0_ready), 64'd0);
        chk("stall_ready1", 64'(wb1_ready), 64'd0);
        cyc();
        chk("stall_wr_en", 64'(rf_wr_en), 64'd0);
        stall = 1'b0;
        settle();
        chk("post_stall_ready1", 64'(wb1_ready), 64'd1);
        chk("post_stall_ready0", 64'(wb0_ready), 64'd0);
        cyc();
        wb1_valid = 1'b0;
        settle();
        chk("post_stall_ready0b", 64'(wb0_ready),   64'd1);
        chk("post_stall_idx",     64'(rf_wr_index), 64'd20);
        $display("stall held rr_ptr, wb1 granted after");

        // 6b. Reset in the cycle after the idx 16 handshake
        cyc();
        rst = 1'b1;
        rd_reg_index_1 = 5'd16;
        settle();
        chk("mid_rst_ready0", 64'(wb0_ready), 64'd0);
        chk("mid_rst_wr_en",  64'(rf_wr_en),  64'd0);
        chk("mid_rst_haz1",   64'(hazard_1),  64'd0);
        cyc();
        rst = 1'b0; wb0_valid = 1'b0;
        settle();
        chk("after_rst_wr_en", 64'(rf_wr_en),    64'd0);
        chk("after_rst_idx",   64'(rf_wr_index), 64'd0);
        chk("after_rst_cnt",   64'(wr_count),    64'd0);
        chk("after_rst_drop",  64'(drop_count),  64'd0);
        $display("reset mid-operation discarded idx 16");

        // Recovery: rr_ptr back to 0, wb0 wins contention
        wb0_valid = 1'b1; wb0_index = 5'd3; wb0_data = 32'h33;
        wb1_valid = 1'b1; wb1_index = 5'd4; wb1_data = 32'h44;
        settle();
        chk("rec_ready0", 64'(wb0_ready), 64'd1);
        chk("rec_ready1", 64'(wb1_ready), 64'd0);
        cyc();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        settle();
        chk("rec_idx",  64'(rf_wr_index), 64'd3);
        chk("rec_data", 64'(rf_wr_data),  64'h33);
        chk("rec_cnt",  64'(wr_count),    64'd1);
        $display("recovery write idx 3");

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
